// File: rtl/intt_flat.sv
// intt_flat: sequential inverse NTT over Z_Q.
// Input is a bit-reversed NTT-domain vector and output is the natural-order
// coefficient vector scaled by D^-1. One Gentleman-Sande stage is applied per
// clock and the D^-1 scaling takes one extra cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; inputs are reduced and loaded on accept
// STAGE | one butterfly stage per cycle, s = 0 .. log2(D)-1
// SCALE | multiply every coefficient by DINV and publish the result on b
// DONE  | one-cycle done pulse, then back to IDLE
module intt_flat #(
  parameter int unsigned N    = 17,
  parameter int unsigned D    = 8,
  parameter int unsigned Q    = 65537,
  parameter int unsigned DINV = 57345
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [D*N-1:0] a,
  output logic           busy,
  output logic           done,
  output logic [D*N-1:0] b
);

  localparam int unsigned LOGD = $clog2(D);
  // Inverse of psi, a primitive 2D-th root of unity mod Q (psi = 4 for the
  // default Q = 65537, D = 8, since 4^8 = 2^16 = -1 mod 65537).
  localparam int unsigned PSI_INV = 49153;
  localparam logic [2*N-1:0] Q_W    = (2*N)'(Q);
  localparam logic [N:0]     Q_S    = (N+1)'(Q);
  localparam logic [N-1:0]   DINV_W = N'(DINV);
  localparam logic [LOGD-1:0] LAST_S = LOGD'(LOGD - 1);

  typedef enum logic [1:0] {IDLE, STAGE, SCALE, DONE} state_t;

  state_t          state, state_nxt;
  logic [LOGD-1:0] s;
  logic [N-1:0]    coef        [D];
  logic [N-1:0]    coef_load   [D];
  logic [N-1:0]    coef_stage  [D];
  logic [N-1:0]    coef_scaled [D];
  logic [D*N-1:0]  b_nxt;
  logic [N-1:0]    psi_inv_rom [D];

  function automatic logic [N-1:0] red_wide(input logic [2*N-1:0] x);
    return N'(x % Q_W);
  endfunction

  function automatic logic [N-1:0] add_mod(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum >= Q_S) sum = sum - Q_S;
    return sum[N-1:0];
  endfunction

  function automatic logic [N-1:0] sub_mod(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] dif;
    dif = {1'b0, x} + Q_S - {1'b0, y};
    if (dif >= Q_S) dif = dif - Q_S;
    return dif[N-1:0];
  endfunction

  function automatic logic [N-1:0] mul_mod(input logic [N-1:0] x, input logic [N-1:0] y);
    return red_wide({{N{1'b0}}, x} * {{N{1'b0}}, y});
  endfunction

  // Entry k = psi^-brv(k) mod Q, brv being a log2(D)-bit reversal.
  function automatic logic [N-1:0] psi_inv_pow(input int unsigned k);
    int unsigned       e;
    longint unsigned   acc;
    e = 0;
    for (int unsigned bi = 0; bi < LOGD; bi++)
      if (((k >> bi) & 32'd1) != 0) e = e | (32'd1 << (LOGD - 1 - bi));
    acc = 64'd1;
    for (int unsigned j = 0; j < e; j++) acc = (acc * 64'(PSI_INV)) % 64'(Q);
    return N'(acc);
  endfunction

  for (genvar gk = 0; gk < D; gk++) begin : g_rom
    assign psi_inv_rom[gk] = psi_inv_pow(gk);
  end

  // Input reduction, D^-1 scaling and packing of the scaled result.
  always_comb begin
    b_nxt = '0;
    for (int k = 0; k < D; k++) begin
      coef_load[k]      = red_wide({{N{1'b0}}, a[N*k +: N]});
      coef_scaled[k]    = mul_mod(coef[k], DINV_W);
      b_nxt[N*k +: N]   = coef_scaled[k];
    end
  end

  // One GS stage: butterfly j works on (top, top + 2^s), twiddle from the ROM.
  always_comb begin
    logic [LOGD-1:0] bf_j, bf_mask, bf_top, bf_bot, bf_tw;
    logic [N-1:0]    bf_u, bf_v;
    coef_stage = coef;
    bf_j = '0; bf_mask = '0; bf_top = '0; bf_bot = '0; bf_tw = '0;
    bf_u = '0; bf_v = '0;
    for (int j = 0; j < D / 2; j++) begin
      bf_j    = LOGD'(j);
      bf_mask = LOGD'((32'd1 << s) - 32'd1);
      bf_top  = ((bf_j >> s) << (s + 1'b1)) | (bf_j & bf_mask);
      bf_bot  = bf_top | LOGD'(32'd1 << s);
      bf_tw   = LOGD'((D >> (s + 1'b1)) + 32'(bf_j >> s));
      bf_u    = coef[bf_top];
      bf_v    = coef[bf_bot];
      coef_stage[bf_top] = add_mod(bf_u, bf_v);
      coef_stage[bf_bot] = mul_mod(sub_mod(bf_u, bf_v), psi_inv_rom[bf_tw]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STAGE;
      STAGE:   if (s == LAST_S) state_nxt = SCALE;
      SCALE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state == STAGE) || (state == SCALE);
    done = (state == DONE);
  end

  // Coefficient store, stage counter and result register; s parks on its
  // last value so the butterfly indices never leave the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < D; k++) coef[k] <= '0;
      s <= '0;
      b <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          coef <= coef_load;
          s    <= '0;
        end
        STAGE: begin
          coef <= coef_stage;
          if (s != LAST_S) s <= s + 1'b1;
        end
        SCALE: begin
          coef <= coef_scaled;
          b    <= b_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intt_flat.sv
// Bench for intt_flat: directed vectors, random round trips through a
// software forward NTT, handshake/throughput and mid-operation abort.
module tb_intt_flat;
  localparam int N = 17;
  localparam int D = 8;
  localparam int Q = 65537;
  localparam int DINV = 57345;
  localparam int LOGD = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [D*N-1:0] a;
  logic           busy;
  logic           done;
  logic [D*N-1:0] b;

  always #5 clk = ~clk;

  intt_flat #(.N(N), .D(D), .Q(Q), .DINV(DINV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .b     (b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [D*N-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [D*N-1:0] obs, input logic [D*N-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // psi = 4 is a primitive 16th root mod 65537; zeta(k) = psi^brv(k).
  function automatic longint unsigned zeta(input int k);
    int e = 0;
    longint unsigned acc = 1;
    for (int bi = 0; bi < LOGD; bi++)
      if (((k >> bi) & 1) != 0) e = e | (1 << (LOGD - 1 - bi));
    for (int j = 0; j < e; j++) acc = (acc * 4) % Q;
    return acc;
  endfunction

  // Forward negacyclic Cooley-Tukey NTT, natural in, bit-reversed out.
  function automatic logic [D*N-1:0] fwd_ntt(input logic [D*N-1:0] x);
    longint unsigned c[D];
    longint unsigned t, z;
    int k;
    logic [D*N-1:0] r;
    for (int i = 0; i < D; i++) c[i] = x[N*i +: N];
    k = 0;
    for (int len = D / 2; len >= 1; len = len / 2)
      for (int st = 0; st < D; st += 2 * len) begin
        k++;
        z = zeta(k);
        for (int j = st; j < st + len; j++) begin
          t = (z * c[j+len]) % Q;
          c[j+len] = (c[j] + Q - t) % Q;
          c[j] = (c[j] + t) % Q;
        end
      end
    r = '0;
    for (int i = 0; i < D; i++) r[N*i +: N] = N'(c[i]);
    return r;
  endfunction

  function automatic logic [D*N-1:0] splat(input int v);
    logic [D*N-1:0] r;
    for (int i = 0; i < D; i++) r[N*i +: N] = N'(v);
    return r;
  endfunction

  function automatic logic [D*N-1:0] lane0(input int v);
    logic [D*N-1:0] r;
    r = '0;
    r[N-1:0] = N'(v);
    return r;
  endfunction

  function automatic logic [D*N-1:0] rnd_vec(input int hi);
    logic [D*N-1:0] r;
    for (int i = 0; i < D; i++) r[N*i +: N] = N'($urandom_range(0, hi));
    return r;
  endfunction

  // Scoreboard: every done must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) chk("unexpected_done", done, 1'b0);
      else                   chk("sb_b", b, exp_q.pop_front());
    end
  end

  task automatic run_vec(input string tag, input logic [D*N-1:0] vec,
                         input logic [D*N-1:0] exp, input bit noise);
    int lat, bcnt;
    @(negedge clk);
    a = vec;
    start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bcnt = int'(busy);
    while (!done && lat < 20) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        a = rnd_vec(131071);
      end
      @(negedge clk);
      lat++;
      bcnt += int'(busy);
    end
    start = 1'b0;
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_busy_cycles"}, bcnt, 4);
    @(negedge clk);
    chk({tag, "_done_fall"}, done, 1'b0);
    for (int h = 0; h < 3; h++) begin
      chk({tag, "_b_hold"}, b, exp);
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run still active at time limit, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [D*N-1:0] x;

    // Reset with start high and random input.
    rst_n = 1'b0;
    start = 1'b1;
    a = rnd_vec(131071);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_b", b, '0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_b", b, '0);

    // Directed vectors.
    run_vec("impulse", splat(1), lane0(1), 1'b0);
    run_vec("scale1234", splat(1234), lane0(1234), 1'b0);
    run_vec("unreduced", splat(65538), lane0(1), 1'b0);
    run_vec("zeros", splat(0), '0, 1'b0);

    // Start pulses and input changes while busy must not disturb the result.
    for (int v = 0; v < 10; v++) begin
      x = rnd_vec(Q - 1);
      run_vec("noise", fwd_ntt(x), x, 1'b1);
    end

    // Start held high: 1000 random round trips, done every 6 cycles.
    start = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      x = rnd_vec(Q - 1);
      a = fwd_ntt(x);
      exp_q.push_back(x);
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        chk("stream_done", done, 1'(c == 5));
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("b_nonzero_before_abort", 1'(b != '0), 1'b1);

    // Abort two cycles after an accepted start.
    @(negedge clk);
    a = rnd_vec(Q - 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_b", b, '0);
    @(negedge clk);
    rst_n = 1'b1;
    x = rnd_vec(Q - 1);
    run_vec("post_abort", fwd_ntt(x), x, 1'b0);

    repeat (4) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/intt_flat.md
# intt_flat

Sequential inverse NTT over Z_Q for one D-coefficient vector. It is the counterpart of the team's forward flat NTT: it takes a bit-reversed-order NTT-domain vector and returns the natural-order coefficient vector, scaled by D^-1 mod Q. It computes one Gentleman–Sande butterfly stage per clock and applies the final scaling in one extra cycle. A start/busy/done handshake frames the computation so the block can be chained after the forward NTT and pointwise multiply.

## Interface
Parameters:
- N, 17: coefficient width in bits.
- D, 8: number of coefficients; a power of two, ≥ 2.
- Q, 65537: prime modulus; must satisfy Q < 2^N.
- DINV, 57345: D^-1 mod Q (8·57345 ≡ 1 mod 65537).

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  D*N  NTT-domain vector; coefficient k is at a[N*(k+1)-1:N*k]; sampled on the start-accept edge.
- busy  output  1  high in the STAGE and SCALE states.
- done  output  1  one-cycle pulse; high only in the DONE state.
- b  output  D*N  result register; same packing as a; valid from done until the next done.

## Operation
- FSM states: IDLE → STAGE → SCALE → DONE → IDLE.
- **IDLE**
  - start=1: load coef[k] ← a[k] mod Q for every k, set stage counter s ← 0, go to STAGE.
  - start=0: stay in IDLE.
- **STAGE** (runs log2(D) cycles, s = 0 … log2(D)-1)
  - span = 2^s. Butterflies act on every pair (i, i+span) with (i/span) even.
  - Twiddle: w = psi_inv_table[(D>>(s+1)) + (i>>(s+1))], where entry k holds psi^-brv(k) mod Q. psi_inv_table is a combinational ROM with the same addr/value ports as psi_table.
  - Update: coef[i] ← (u+v) mod Q; coef[i+span] ← ((u−v+Q) mod Q)·w mod Q, with u = coef[i] and v = coef[i+span].
  - s increments each cycle. After s = log2(D)-1, go to SCALE.
- **SCALE** (1 cycle): coef[k] ← coef[k]·DINV mod Q, and b ← the scaled values in the same edge. Go to DONE.
- **DONE** (1 cycle): done=1. Go to IDLE.
- start is ignored in STAGE, SCALE and DONE. There is no queueing. A start held high is accepted on the first IDLE cycle.
- Width rules:
  - Sums use N+1 bits.
  - Products use 2N bits, then a full reduction mod Q.
  - Every stored coefficient and every b lane is in [0, Q-1].
- b changes only on the SCALE edge or on reset, and holds its value otherwise.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State IDLE, s = 0, busy = 0, done = 0.
  - b = 0 and all internal coef = 0.
- Latency, counting the start-accept edge as edge 1:
  - busy rises after edge 1.
  - b updates and done rises after edge log2(D)+2 (edge 5 for D=8).
  - done falls after edge log2(D)+3.
- Throughput: one vector per log2(D)+3 cycles (6 for D=8), with start held high.
- Reset asserted mid-operation: the computation is aborted immediately and all outputs go to their reset values. No done is produced for the aborted vector.
- A start that is high during the DONE cycle is not accepted until the following IDLE cycle.

## Test plan
- **Reset:** rst_n=0 with start=1 and random a → busy=0, done=0, b=0. Release reset with start=0 → outputs stay 0 and done never pulses.
- **Impulse recovery:** all eight a lanes = 1, pulse start → done after edge 5. Then b lane0 = 1, lanes 1–7 = 0; busy high for exactly 4 cycles.
- **Scaling and input reduction:**
  - All lanes = 1234 → b = (1234, 0, …, 0).
  - All lanes = 65538 (≥Q) → b = (1, 0, …, 0).
  - All lanes = 0 → b all 0.
- **Round trip:** 1000 random vectors with lanes in [0, 65536] run through the forward NTT, then intt_flat → b equals the original vector exactly. Compare against a software GS reference on every done.
- **Handshake:**
  - start held high continuously → done every 6 cycles.
  - Extra start pulses during busy or done → no effect. b stays stable between done pulses.
- **Abort:** assert rst_n=0 two cycles after an accepted start → busy, done and b are 0 immediately. A fresh start after release produces the correct result after edge 5.
